// File: rtl/sort_pingpong_sched_pkg.sv
// rtl/sort_pingpong_sched_pkg.sv - shared types for the ping-pong sort scheduler
package sort_sched_pkg;

  localparam int NUM_ENG = 2;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    LOAD,
    RUN,
    SORT
  } eng_state_t;

endpackage

// File: rtl/sort_pingpong_sched_if.sv
// rtl/sort_pingpong_sched_if.sv - framed word stream bundle (data/valid/sop/eop/ready)
interface sort_pingpong_sched_if #(
  parameter int DWIDTH = 8
) ();

  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);

endinterface

// File: rtl/sort_pingpong_sched_eng_fsm.sv
// rtl/sort_pingpong_sched_eng_fsm.sv - per-engine control FSM: clear, load, run strobe, sort/drain
module sort_sched_eng_fsm
  import sort_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       close_i,
  input  logic       drain_done_i,
  output eng_state_t state_o,
  output logic       srst_o,
  output logic       run_o,
  output logic       load_ok_o
);

  eng_state_t state_q;
  logic       srst_q;
  logic       run_q;

  // RUN lasts one cycle so the final registered write reaches the engine before the run strobe
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLR;
      srst_q  <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      srst_q <= 1'b0;
      run_q  <= 1'b0;
      case (state_q)
        CLR:  state_q <= IDLE;
        IDLE: if (start_i) state_q <= close_i ? RUN : LOAD;
        LOAD: if (close_i) state_q <= RUN;
        RUN: begin
          run_q   <= 1'b1;
          state_q <= SORT;
        end
        SORT: if (drain_done_i) begin
          state_q <= CLR;
          srst_q  <= 1'b1;
        end
        default: state_q <= CLR;
      endcase
    end
  end

  assign state_o   = state_q;
  assign srst_o    = srst_q;
  assign run_o     = run_q;
  assign load_ok_o = (state_q == IDLE) || (state_q == LOAD);

endmodule

// File: rtl/sort_pingpong_sched.sv
// rtl/sort_pingpong_sched.sv - ping-pong scheduler for two sort engines; SORT_SCHED_STATS_EN adds frame/overflow counters
module sort_pingpong_sched
  import sort_sched_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [DWIDTH-1:0]   in_data_i,
  input  logic                in_valid_i,
  input  logic                in_sop_i,
  input  logic                in_eop_i,
  output logic                in_ready_o,
  output logic [1:0]          eng_srst_o,
  output logic [1:0]          eng_run_o,
  output logic [1:0]          eng_wr_req_o,
  output logic [DWIDTH-1:0]   eng_wr_data_o,
  input  logic [2*DWIDTH-1:0] eng_out_data_i,
  input  logic [1:0]          eng_out_valid_i,
  input  logic [1:0]          eng_out_sop_i,
  input  logic [1:0]          eng_out_eop_i,
  output logic [1:0]          eng_out_ready_o,
  output logic [DWIDTH-1:0]   out_data_o,
  output logic                out_valid_o,
  output logic                out_sop_o,
  output logic                out_eop_o,
  input  logic                out_ready_i,
  output logic                ovf_o,
  output logic                err_o
`ifdef SORT_SCHED_STATS_EN
  ,
  output logic [15:0]         stat_frames_o,
  output logic [15:0]         stat_ovf_o
`endif
);

  localparam logic [AWIDTH:0] MAXLEN_W = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE_W    = {{AWIDTH{1'b0}}, 1'b1};

  eng_state_t        state [NUM_ENG];
  logic [1:0]        load_ok;
  logic [1:0]        start;
  logic [1:0]        close;
  logic [1:0]        drain_done;

  logic              ld_sel_q, ld_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [AWIDTH:0]   wcnt_q, wcnt_d;
  logic              in_frame_q, in_frame_d;
  logic              skip_q, skip_d;
  logic [1:0]        wr_req_q, wr_req_d;
  logic [DWIDTH-1:0] wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              accept;
  logic              drain_hs;
  logic [AWIDTH:0]   wcnt_inc;

  assign in_ready_o = load_ok[ld_sel_q];
  assign accept     = in_valid_i && in_ready_o;
  assign wcnt_inc   = wcnt_q + ONE_W;

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
    sort_sched_eng_fsm u_fsm (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start[g]),
      .close_i      (close[g]),
      .drain_done_i (drain_done[g]),
      .state_o      (state[g]),
      .srst_o       (eng_srst_o[g]),
      .run_o        (eng_run_o[g]),
      .load_ok_o    (load_ok[g])
    );
    assign drain_done[g] = drain_hs && (rd_sel_q == 1'(g)) && (state[g] == SORT);
  end

  // skip_q: frame truncated at MAXLEN, swallow words up to its eop
  always_comb begin
    start      = 2'b00;
    close      = 2'b00;
    ld_sel_d   = ld_sel_q;
    wcnt_d     = wcnt_q;
    in_frame_d = in_frame_q;
    skip_d     = skip_q;
    wr_req_d   = 2'b00;
    wr_data_d  = wr_data_q;
    ovf_d      = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      if (skip_q) begin
        if (in_eop_i) skip_d = 1'b0;
      end else if (!in_frame_q) begin
        if (in_sop_i) begin
          start[ld_sel_q]    = 1'b1;
          wr_req_d[ld_sel_q] = 1'b1;
          wr_data_d          = in_data_i;
          wcnt_d             = ONE_W;
          if (in_eop_i) begin
            close[ld_sel_q] = 1'b1;
            ld_sel_d        = ~ld_sel_q;
          end else begin
            in_frame_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d              = in_sop_i;
        wr_req_d[ld_sel_q] = 1'b1;
        wr_data_d          = in_data_i;
        wcnt_d             = wcnt_inc;
        if (in_eop_i || (wcnt_inc == MAXLEN_W)) begin
          close[ld_sel_q] = 1'b1;
          ld_sel_d        = ~ld_sel_q;
          in_frame_d      = 1'b0;
          if (!in_eop_i) begin
            ovf_d  = 1'b1;
            skip_d = 1'b1;
          end
        end
      end
    end
  end

  assign rd_sel_d = (|drain_done) ? ~rd_sel_q : rd_sel_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wcnt_q     <= '0;
      in_frame_q <= 1'b0;
      skip_q     <= 1'b0;
      wr_req_q   <= 2'b00;
      wr_data_q  <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_sel_q   <= ld_sel_d;
      rd_sel_q   <= rd_sel_d;
      wcnt_q     <= wcnt_d;
      in_frame_q <= in_frame_d;
      skip_q     <= skip_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign eng_wr_req_o  = wr_req_q;
  assign eng_wr_data_o = wr_data_q;
  assign ovf_o         = ovf_q;
  assign err_o         = err_q;

  assign out_data_o      = rd_sel_q ? eng_out_data_i[2*DWIDTH-1:DWIDTH] : eng_out_data_i[DWIDTH-1:0];
  assign out_valid_o     = eng_out_valid_i[rd_sel_q];
  assign out_sop_o       = eng_out_sop_i[rd_sel_q];
  assign out_eop_o       = eng_out_eop_i[rd_sel_q];
  assign eng_out_ready_o = rd_sel_q ? {out_ready_i, 1'b0} : {1'b0, out_ready_i};
  assign drain_hs        = out_valid_o && out_ready_i && out_eop_o;

`ifdef SORT_SCHED_STATS_EN
  logic [15:0] stat_frames_q;
  logic [15:0] stat_ovf_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_frames_q <= '0;
      stat_ovf_q    <= '0;
    end else begin
      if ((|drain_done) && (stat_frames_q != 16'hFFFF)) stat_frames_q <= stat_frames_q + 16'd1;
      if (ovf_d && (stat_ovf_q != 16'hFFFF))             stat_ovf_q    <= stat_ovf_q + 16'd1;
    end
  end

  assign stat_frames_o = stat_frames_q;
  assign stat_ovf_o    = stat_ovf_q;
`endif

endmodule

// File: tb/tb_sort_pingpong_sched.sv
// tb/tb_sort_pingpong_sched.sv - self-checking bench with behavioural engines and frame scoreboard
module tb_sort_pingpong_sched;

  localparam int AW     = 2;
  localparam int DW     = 8;
  localparam int MAXLEN = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_pingpong_sched_if #(.DWIDTH(DW)) up_if ();
  sort_pingpong_sched_if #(.DWIDTH(DW)) dn_if ();

  logic [1:0]      eng_srst, eng_run, eng_wr_req, eng_out_ready;
  logic [1:0]      eng_out_valid, eng_out_sop, eng_out_eop;
  logic [DW-1:0]   eng_wr_data;
  logic [2*DW-1:0] eng_out_data;
  logic            ovf, err;
`ifdef SORT_SCHED_STATS_EN
  logic [15:0]     stat_frames, stat_ovf;
`endif

  sort_pingpong_sched #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .in_data_i       (up_if.data),
    .in_valid_i      (up_if.valid),
    .in_sop_i        (up_if.sop),
    .in_eop_i        (up_if.eop),
    .in_ready_o      (up_if.ready),
    .eng_srst_o      (eng_srst),
    .eng_run_o       (eng_run),
    .eng_wr_req_o    (eng_wr_req),
    .eng_wr_data_o   (eng_wr_data),
    .eng_out_data_i  (eng_out_data),
    .eng_out_valid_i (eng_out_valid),
    .eng_out_sop_i   (eng_out_sop),
    .eng_out_eop_i   (eng_out_eop),
    .eng_out_ready_o (eng_out_ready),
    .out_data_o      (dn_if.data),
    .out_valid_o     (dn_if.valid),
    .out_sop_o       (dn_if.sop),
    .out_eop_o       (dn_if.eop),
    .out_ready_i     (dn_if.ready),
    .ovf_o           (ovf),
    .err_o           (err)
`ifdef SORT_SCHED_STATS_EN
    ,
    .stat_frames_o   (stat_frames),
    .stat_ovf_o      (stat_ovf)
`endif
  );

  // Behavioural gnome-sort engines: store writes, sort descending on run, stream after a random delay
  logic [DW-1:0] emem [2][MAXLEN];
  logic [DW-1:0] omem [2][MAXLEN];
  int            ecnt [2];
  int            olen [2];
  int            oidx [2];
  int            edly [2];
  logic [1:0]    ebusy, oval;

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] sq[$];
    if (!rst_n) begin
      ebusy <= 2'b00;
      oval  <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        ecnt[k] <= 0; olen[k] <= 1; oidx[k] <= 0; edly[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (eng_srst[k]) begin
          ecnt[k] <= 0; oidx[k] <= 0; ebusy[k] <= 1'b0; oval[k] <= 1'b0;
        end else begin
          if (eng_wr_req[k] && ecnt[k] < MAXLEN) begin
            emem[k][ecnt[k]] <= eng_wr_data;
            ecnt[k]          <= ecnt[k] + 1;
          end
          if (eng_run[k]) begin
            sq.delete();
            for (int i = 0; i < ecnt[k]; i++) sq.push_back(emem[k][i]);
            sq.rsort();
            for (int i = 0; i < ecnt[k]; i++) omem[k][i] <= sq[i];
            olen[k]  <= ecnt[k];
            oidx[k]  <= 0;
            edly[k]  <= int'($urandom_range(0, 3));
            ebusy[k] <= 1'b1;
          end else if (ebusy[k] && !oval[k]) begin
            if (edly[k] > 0) edly[k] <= edly[k] - 1;
            else oval[k] <= 1'b1;
          end else if (oval[k] && eng_out_ready[k]) begin
            if (oidx[k] == olen[k] - 1) begin
              oval[k]  <= 1'b0;
              ebusy[k] <= 1'b0;
            end else begin
              oidx[k] <= oidx[k] + 1;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_eo
    assign eng_out_valid[g]         = oval[g];
    assign eng_out_data[g*DW +: DW] = omem[g][oidx[g]];
    assign eng_out_sop[g]           = (oidx[g] == 0);
    assign eng_out_eop[g]           = (oidx[g] == olen[g] - 1);
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dn_if.ready = 1'b0;
      1:       dn_if.ready = 1'b1;
      default: dn_if.ready = ($urandom_range(0, 99) < 60);
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         pass_cnt = 0;
  int         tot_cnt  = 0;
  int         err_seen, ovf_seen, stall_cnt, eop_acc_cyc;
  int         run_cyc [2];
  int         run_order[$];
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (ovf) ovf_seen++;
      for (int k = 0; k < 2; k++)
        if (eng_run[k]) begin run_order.push_back(k); run_cyc[k] = cyc; end
      if (up_if.valid && up_if.ready && up_if.eop) eop_acc_cyc = cyc;
      if (up_if.valid && !up_if.ready) stall_cnt++;
      if (dn_if.valid && dn_if.ready) got_q.push_back({dn_if.sop, dn_if.eop, dn_if.data});
    end
  end

  // Reference model: frame assembly rules on plain lists
  bit            m_in_frame, m_skip;
  logic [DW-1:0] m_frame[$];
  int            exp_err, exp_ovf, exp_frames;

  task automatic model_close();
    m_in_frame = 0;
    m_frame.rsort();
    foreach (m_frame[i])
      exp_q.push_back({(i == 0), (i == m_frame.size() - 1), m_frame[i]});
    exp_frames++;
  endtask

  task automatic model_word(input logic [DW-1:0] d, input bit sop, input bit eop);
    if (m_skip) begin
      if (eop) m_skip = 0;
    end else if (!m_in_frame && !sop) begin
      exp_err++;
    end else begin
      if (!m_in_frame) m_frame.delete();
      else if (sop) exp_err++;
      m_frame.push_back(d);
      if (eop) model_close();
      else if (m_frame.size() == MAXLEN) begin
        exp_ovf++;
        m_skip = 1;
        model_close();
      end else m_in_frame = 1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit sop, input bit eop);
    int n = 0;
    model_word(d, sop, eop);
    up_if.data  = d;
    up_if.sop   = sop;
    up_if.eop   = eop;
    up_if.valid = 1'b1;
    @(negedge clk);
    while (!up_if.ready && n < 2000) begin n++; @(negedge clk); end
    if (n >= 2000) begin
      tot_cnt++;
      $display("FAIL send_timeout got=stalled exp=accepted data=%0d", d);
    end
    @(posedge clk); #1;
    up_if.valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 20000) begin n++; @(negedge clk); end
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    else begin
      pass_cnt++;
      foreach (exp_q[i]) begin
        tot_cnt++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL %s_word%0d got=%h exp=%h", name, i, got_q[i], exp_q[i]);
        else pass_cnt++;
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    up_if.valid = 1'b0;
    up_if.sop   = 1'b0;
    up_if.eop   = 1'b0;
    up_if.data  = '0;
    repeat (2) @(posedge clk); #1;
    got_q.delete(); exp_q.delete(); run_order.delete(); m_frame.delete();
    m_in_frame = 0; m_skip = 0;
    exp_err = 0; exp_ovf = 0; exp_frames = 0;
    err_seen = 0; ovf_seen = 0; stall_cnt = 0; eop_acc_cyc = -100;
    run_cyc[0] = -100; run_cyc[1] = -100;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if (up_if.ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", up_if.ready); else pass_cnt++;
    tot_cnt++;
    if (eng_srst !== 2'b11) $display("FAIL reset_srst got=%b exp=11", eng_srst); else pass_cnt++;
    tot_cnt++;
    if ({eng_run, eng_wr_req, ovf, err} !== 6'b0)
      $display("FAIL reset_strobes got=%b exp=000000", {eng_run, eng_wr_req, ovf, err});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tot_cnt++;
    if ({eng_srst, up_if.ready} !== 3'b001)
      $display("FAIL reset_release got=%b exp=001", {eng_srst, up_if.ready});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    rdy_mode = 1;
    send_word(8'd5, 1, 0);
    send_word(8'd3, 0, 0);
    send_word(8'd9, 0, 0);
    send_word(8'd1, 0, 1);
    wait_drain("basic");
    tot_cnt++;
    if (run_cyc[0] - eop_acc_cyc !== 2)
      $display("FAIL basic_run_latency got=%0d exp=2", run_cyc[0] - eop_acc_cyc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_mode = 1;
    send_word(8'd2, 1, 0);
    send_word(8'd7, 0, 1);
    stall_cnt = 0;
    send_word(8'd4, 1, 0);
    send_word(8'd8, 0, 0);
    send_word(8'd1, 0, 1);
    tot_cnt++;
    if (stall_cnt !== 0) $display("FAIL b2b_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    wait_drain("b2b");
    tot_cnt++;
    if (run_order.size() != 2 || run_order[0] != 0 || run_order[1] != 1)
      $display("FAIL b2b_engine_order got=%p exp=0,1", run_order);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 0;
    send_word(8'd3, 1, 0);
    send_word(8'd1, 0, 0);
    send_word(8'd2, 0, 1);
    send_word(8'd6, 1, 0);
    send_word(8'd5, 0, 1);
    repeat (8) @(negedge clk);
    tot_cnt++;
    if (up_if.ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", up_if.ready); else pass_cnt++;
    rdy_mode = 1;
    send_word(8'd9, 1, 0);
    send_word(8'd8, 0, 0);
    send_word(8'd7, 0, 1);
    wait_drain("bp");
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_mode = 1;
    for (int i = 1; i <= 6; i++) send_word(8'(i), i == 1, i == 6);
    wait_drain("ovf");
    tot_cnt++;
    if (ovf_seen !== 1) $display("FAIL ovf_pulses got=%0d exp=1", ovf_seen); else pass_cnt++;
    tot_cnt++;
    if (err_seen !== 0) $display("FAIL ovf_err got=%0d exp=0", err_seen); else pass_cnt++;
  endtask

  task automatic test_errors();
    do_reset();
    rdy_mode = 1;
    send_word(8'd77, 0, 0);
    send_word(8'd10, 1, 0);
    send_word(8'd20, 0, 0);
    send_word(8'd30, 1, 0);
    send_word(8'd40, 0, 1);
    wait_drain("err");
    tot_cnt++;
    if (err_seen !== exp_err || exp_err != 2)
      $display("FAIL err_pulses got=%0d exp=2", err_seen);
    else pass_cnt++;
    tot_cnt++;
    if (ovf_seen !== 0) $display("FAIL err_ovf got=%0d exp=0", ovf_seen); else pass_cnt++;
  endtask

  task automatic test_random();
    int len;
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 100; f++) begin
      len = int'($urandom_range(1, MAXLEN + 2));
      for (int i = 0; i < len; i++) send_word(8'($urandom), i == 0, i == len - 1);
    end
    wait_drain("rand");
    tot_cnt++;
    if (ovf_seen !== exp_ovf) $display("FAIL rand_ovf got=%0d exp=%0d", ovf_seen, exp_ovf); else pass_cnt++;
    tot_cnt++;
    if (err_seen !== 0) $display("FAIL rand_err got=%0d exp=0", err_seen); else pass_cnt++;
`ifdef SORT_SCHED_STATS_EN
    tot_cnt++;
    if (stat_frames !== 16'(exp_frames))
      $display("FAIL rand_stat_frames got=%0d exp=%0d", stat_frames, exp_frames);
    else pass_cnt++;
    tot_cnt++;
    if (stat_ovf !== 16'(exp_ovf))
      $display("FAIL rand_stat_ovf got=%0d exp=%0d", stat_ovf, exp_ovf);
    else pass_cnt++;
`endif
  endtask

  initial begin
    up_if.valid = 1'b0;
    up_if.sop   = 1'b0;
    up_if.eop   = 1'b0;
    up_if.data  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_errors();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
